// File: rtl/ahb_reg_slave.sv
// AHB-Lite slave exposing NUM_REGS 32-bit registers. Register 0 is a read-only ID.
// Each OKAY transfer has WAIT_STATES wait cycles; errors get a two-cycle ERROR response.
module ahb_reg_slave #(
    parameter int          NUM_REGS    = 16,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5A0_0001
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              ahb_s_haddr_i,
    input  logic                     ahb_s_hwrite_i,
    input  logic [2:0]               ahb_s_hsize_i,
    input  logic [2:0]               ahb_s_hburst_i,
    input  logic [3:0]               ahb_s_hprot_i,
    input  logic [1:0]               ahb_s_htrans_i,
    input  logic                     ahb_s_hmastlock_i,
    input  logic [31:0]              ahb_s_hwdata_i,
    output logic                     ahb_s_hready_o,
    output logic                     ahb_s_hresp_o,
    output logic [31:0]              ahb_s_hrdata_o,
    output logic [NUM_REGS*32-1:0]   reg_q_o
);
    localparam int          IW = $clog2(NUM_REGS);
    localparam logic [3:0]  WS = 4'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_hready;
    logic           r_hresp;
    logic [31:0]    r_hrdata;
    logic [IW-1:0]  r_idx;
    logic           r_write;
    logic [31:0]    r_regs [NUM_REGS];

    logic           w_accept;
    logic           w_err;
    logic [IW-1:0]  w_idx;
    logic           w_commit;
    logic [31:0]    w_fwd_data;
    logic           w_unused;

    assign w_unused = ^{ahb_s_hburst_i, ahb_s_hprot_i, ahb_s_hmastlock_i,
                        ahb_s_haddr_i[31:30], ahb_s_htrans_i[0]};

    // htrans[1] distinguishes NSEQ/SEQ from IDLE/BUSY
    assign w_accept = r_hready && ahb_s_htrans_i[1];
    assign w_idx    = ahb_s_haddr_i[2 +: IW];
    assign w_err    = (ahb_s_hsize_i != 3'b010)
                   || (|ahb_s_haddr_i[29:IW+2])
                   || (|ahb_s_haddr_i[1:0])
                   || (ahb_s_hwrite_i && (w_idx == '0));
    assign w_commit = (r_state == S_DATA) && r_write;

    // Zero-wait reads right behind a write to the same index must see the data being committed
    assign w_fwd_data = (w_commit && (r_idx == w_idx)) ? ahb_s_hwdata_i : r_regs[w_idx];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_hready <= 1'b1;
            r_hresp  <= 1'b0;
            r_hrdata <= 32'h0;
            r_idx    <= '0;
            r_write  <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state  <= S_DATA;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                        if (!r_write) r_hrdata <= r_regs[r_idx];
                    end
                end
                S_ERR1: begin
                    r_state  <= S_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 1'b1;
                end
                default: begin
                    if (w_accept) begin
                        r_idx   <= w_idx;
                        r_write <= ahb_s_hwrite_i;
                        if (w_err) begin
                            r_state  <= S_ERR1;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            r_state  <= S_DATA;
                            r_hready <= 1'b1;
                            r_hresp  <= 1'b0;
                            if (!ahb_s_hwrite_i) r_hrdata <= w_fwd_data;
                        end else begin
                            r_state  <= S_WAIT;
                            r_cnt    <= WS;
                            r_hready <= 1'b0;
                            r_hresp  <= 1'b0;
                        end
                    end else begin
                        r_state  <= S_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Writes land on the edge that ends the DATA cycle; idx 0 writes never reach DATA
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == 0) ? ID_VALUE : 32'h0;
            end
        end else if (w_commit) begin
            r_regs[r_idx] <= ahb_s_hwdata_i;
        end
    end

    always_comb begin
        reg_q_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q_o[32*i +: 32] = r_regs[i];
        end
    end

    assign ahb_s_hready_o = r_hready;
    assign ahb_s_hresp_o  = r_hresp;
    assign ahb_s_hrdata_o = r_hrdata;
endmodule

// File: doc/ahb_reg_slave.md
AHB_REG_SLAVE -- requirements
Module: ahb_reg_slave

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers; power of two, 2..256.
REQ-002 SHALL have parameter WAIT_STATES, default 1, wait cycles inserted per OKAY data phase; range 0..15.
REQ-003 SHALL have parameter ID_VALUE, default 32'hA5A0_0001, read-only contents of register 0.
REQ-004 SHALL have one clock, `clk`; reset is `resetn`, asynchronous and active-low.
REQ-005 Port list, as name / direction / width / meaning:
- clk / input / 1 / clock.
- resetn / input / 1 / asynchronous active-low reset.
- ahb_s_haddr_i / input / 32 / address.
- ahb_s_hwrite_i / input / 1 / 1 = write.
- ahb_s_hsize_i / input / 3 / transfer size.
- ahb_s_hburst_i / input / 3 / ignored.
- ahb_s_hprot_i / input / 4 / ignored.
- ahb_s_htrans_i / input / 2 / 00 IDLE, 01 BUSY, 10 NSEQ, 11 SEQ.
- ahb_s_hmastlock_i / input / 1 / ignored.
- ahb_s_hwdata_i / input / 32 / write data, valid in data phase.
- ahb_s_hready_o / output / 1 / data phase completes this cycle.
- ahb_s_hresp_o / output / 1 / 1 = ERROR.
- ahb_s_hrdata_o / output / 32 / read data.
- reg_q_o / output / NUM_REGS*32 / all register contents; register i occupies bits [32i+31:32i].

Function
REQ-006 SHALL decode the register index as idx = haddr[2 +: log2(NUM_REGS)]; haddr[29:2+log2(NUM_REGS)] and haddr[1:0] are the out-of-range bits.
REQ-007 SHALL accept an address phase on a rising edge when ahb_s_hready_o = 1 and htrans is NSEQ or SEQ; BUSY and IDLE SHALL be treated as no transfer.
REQ-008 SHALL flag a transfer as an error at acceptance if any of: hsize != 3'b010; any out-of-range bit is nonzero; a write targets idx 0.
REQ-009 SHALL implement a state machine with states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-010 From IDLE, or from DATA/ERR2 on its completing edge, an accepted OKAY transfer SHALL go to WAIT with counter = WAIT_STATES; if WAIT_STATES = 0 it SHALL go directly to DATA.
REQ-011 In WAIT: hready_o = 0, hresp_o = 0; the counter SHALL decrement each cycle; the state SHALL move to DATA when the counter reaches 1.
REQ-012 DATA SHALL drive hready_o = 1, hresp_o = 0 for exactly one cycle.
REQ-013 An accepted error transfer SHALL go to ERR1 (hready_o = 0, hresp_o = 1), then to ERR2 (hready_o = 1, hresp_o = 1), with no wait states inserted.
REQ-014 With no new accepted transfer, DATA and ERR2 SHALL return to IDLE (hready_o = 1, hresp_o = 0).
REQ-015 hready_o and hresp_o SHALL be registered outputs.
REQ-016 Address, hwrite and idx SHALL be captured at acceptance and held for the whole data phase.
REQ-017 A write SHALL commit hwdata_i to register idx on the edge ending the DATA cycle; hwdata_i is sampled in that cycle.
REQ-018 Errored writes SHALL NOT modify any register.
REQ-019 For a read, hrdata_o SHALL present register idx during the DATA cycle, and register 0 SHALL read ID_VALUE.
REQ-020 hrdata_o SHALL hold its previous value during errors and writes.
REQ-021 Back-to-back: a read in the data phase immediately following a write to the same idx SHALL return the newly written value.
REQ-022 A new address phase presented while hready_o = 0 SHALL be ignored.
REQ-023 reg_q_o SHALL update on the same edge as the write commit.
REQ-024 Total OKAY data-phase length SHALL be WAIT_STATES+1 cycles.

Reset
REQ-025 resetn low SHALL asynchronously force: state IDLE, counter 0, hready_o = 1, hresp_o = 0, hrdata_o = 0, registers 1..NUM_REGS-1 = 0, register 0 = ID_VALUE.
REQ-026 Reset asserted mid-transfer SHALL abort the transfer with no register write; after release the slave SHALL accept a new NSEQ on the first edge.

Verification
REQ-027 Reset, then read addr 0x4000_0000 with WAIT_STATES = 1 -> hready_o low for 1 cycle, then high with hrdata_o = 32'hA5A0_0001 and hresp_o = 0.
REQ-028 Write 0xDEADBEEF to 0x4000_0008, then a pipelined read of 0x4000_0008 -> register 2 = 0xDEADBEEF; the read returns 0xDEADBEEF; reg_q_o[95:64] = 0xDEADBEEF.
REQ-029 Write to 0x4000_0000 -> ERR1 then ERR2 (hresp_o = 1 for 2 cycles, hready_o = 0 then 1); register 0 stays ID_VALUE.
REQ-030 Read with hsize = 3'b000, or from address 0x4000_0100 (NUM_REGS = 16) -> two-cycle ERROR response; hrdata_o unchanged.
REQ-031 WAIT_STATES = 0 with back-to-back NSEQ writes to idx 1 then idx 3 -> hready_o stays 1; each write commits one cycle after its address phase.
REQ-032 Assert resetn low during WAIT of a write to idx 5 -> register 5 = 0; hready_o = 1 immediately; the next NSEQ is accepted normally.
